// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer tone scheduler: FSM states, default widths
// and ax_pwm phase-increment words for musical notes at a 50 MHz clock.
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_PWM_N = 32;
  localparam int DEF_LEN_W = 32;

  // Period words are phase increments: f_note * 2^32 / 50 MHz
  localparam logic [31:0] NOTE_C5 = 32'd44947;
  localparam logic [31:0] NOTE_D5 = 32'd50451;
  localparam logic [31:0] NOTE_E5 = 32'd56630;
  localparam logic [31:0] NOTE_F5 = 32'd59997;
  localparam logic [31:0] NOTE_G5 = 32'd67344;
  localparam logic [31:0] NOTE_A5 = 32'd75591;
  localparam logic [31:0] NOTE_B5 = 32'd84848;
  localparam logic [31:0] NOTE_C6 = 32'd89893;
  localparam logic [31:0] NOTE_REST = 32'd0;

endpackage

// File: rtl/buzzer_tone_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[IW'(pos)]) begin
        found         = 1'b1;
        gnt[IW'(pos)] = 1'b1;
        idx           = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/buzzer_tone_sched.sv
// Shares one ax_pwm channel between N_REQ requesters: round-robin grant, timed
// tone playback, optional silent gap, abort via stop. All outputs registered.
module buzzer_tone_sched
  import buzzer_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PWM_N      = DEF_PWM_N,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int GAP_CYCLES = 2500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PWM_N-1:0] req_period,
  input  logic [N_REQ*PWM_N-1:0] req_duty,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic                   stop,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [PWM_N-1:0]       pwm_period,
  output logic [PWM_N-1:0]       pwm_duty,
  output logic                   buzzer_en
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t state, state_nx;

  logic [IW-1:0]    ptr, ptr_nx, owner, owner_nx, win_idx;
  logic [N_REQ-1:0] win_gnt, grant_nx, done_nx;
  logic [LEN_W-1:0] len_lat, len_lat_nx, cnt, cnt_nx;
  logic [GW-1:0]    gap_cnt, gap_cnt_nx;
  logic [PWM_N-1:0] period_nx, duty_nx;
  logic             en_nx, busy_nx;

  logic [PWM_N-1:0] per_arr  [N_REQ];
  logic [PWM_N-1:0] duty_arr [N_REQ];
  logic [LEN_W-1:0] len_arr  [N_REQ];
  logic [PWM_N-1:0] sel_period, sel_duty;
  logic [LEN_W-1:0] sel_len;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign per_arr[g]  = req_period[g*PWM_N +: PWM_N];
    assign duty_arr[g] = req_duty[g*PWM_N +: PWM_N];
    assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
  end

  assign sel_period = per_arr[win_idx];
  assign sel_duty   = duty_arr[win_idx];
  assign sel_len    = len_arr[win_idx];

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    owner_nx   = owner;
    len_lat_nx = len_lat;
    cnt_nx     = cnt;
    gap_cnt_nx = gap_cnt;
    grant_nx   = '0;
    done_nx    = '0;
    period_nx  = pwm_period;
    duty_nx    = pwm_duty;
    en_nx      = buzzer_en;

    case (state)
      ST_IDLE: begin
        if (!stop && |req) begin
          grant_nx   = win_gnt;
          owner_nx   = win_idx;
          ptr_nx     = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          len_lat_nx = (sel_len == '0) ? LEN_W'(1) : sel_len;
          cnt_nx     = LEN_W'(1);
          period_nx  = sel_period;
          duty_nx    = sel_duty;
          en_nx      = |sel_period;
          state_nx   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_nx  = ST_IDLE;
          cnt_nx    = '0;
          period_nx = '0;
          duty_nx   = '0;
          en_nx     = 1'b0;
        end else if (cnt == len_lat) begin
          done_nx[owner] = 1'b1;
          cnt_nx         = '0;
          period_nx      = '0;
          duty_nx        = '0;
          en_nx          = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx   = ST_GAP;
            gap_cnt_nx = GW'(1);
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (stop || gap_cnt == GW'(GAP_CYCLES)) begin
          state_nx   = ST_IDLE;
          gap_cnt_nx = '0;
        end else begin
          gap_cnt_nx = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nx   = ST_IDLE;
        cnt_nx     = '0;
        gap_cnt_nx = '0;
        period_nx  = '0;
        duty_nx    = '0;
        en_nx      = 1'b0;
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      len_lat    <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      pwm_period <= '0;
      pwm_duty   <= '0;
      buzzer_en  <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      owner      <= owner_nx;
      len_lat    <= len_lat_nx;
      cnt        <= cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      grant      <= grant_nx;
      done       <= done_nx;
      busy       <= busy_nx;
      pwm_period <= period_nx;
      pwm_duty   <= duty_nx;
      buzzer_en  <= en_nx;
    end
  end

endmodule

// File: tb/tb_buzzer_tone_sched.sv
// Bench for buzzer_tone_sched: two instances (gap of 4 clocks and no gap) checked
// every cycle against a timeline model of tones granted, played and spaced.
module tb_buzzer_tone_sched;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int GAP_A = 4;
  localparam int GAP_B = 0;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_period, req_duty, req_len;
  logic           stop;

  logic [N-1:0] grant_a, done_a, grant_b, done_b;
  logic         busy_a, en_a, busy_b, en_b;
  logic [W-1:0] per_a, duty_a, per_b, duty_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          m_active [2];
  int          m_start  [2];
  int          m_len    [2];
  int          m_owner  [2];
  int          m_ptr    [2];
  logic [31:0] m_per    [2];
  logic [31:0] m_duty   [2];

  always #5 clk = ~clk;

  buzzer_tone_sched #(.N_REQ(N), .PWM_N(W), .LEN_W(W), .GAP_CYCLES(GAP_A)) dut_gap (
    .clk(clk), .rst(rst), .req(req), .req_period(req_period), .req_duty(req_duty),
    .req_len(req_len), .stop(stop), .grant(grant_a), .done(done_a), .busy(busy_a),
    .pwm_period(per_a), .pwm_duty(duty_a), .buzzer_en(en_a)
  );

  buzzer_tone_sched #(.N_REQ(N), .PWM_N(W), .LEN_W(W), .GAP_CYCLES(GAP_B)) dut_nogap (
    .clk(clk), .rst(rst), .req(req), .req_period(req_period), .req_duty(req_duty),
    .req_len(req_len), .stop(stop), .grant(grant_b), .done(done_b), .busy(busy_b),
    .pwm_period(per_b), .pwm_duty(duty_b), .buzzer_en(en_b)
  );

  function automatic int gap_of(input int d);
    return (d == 0) ? GAP_A : GAP_B;
  endfunction

  // A scheduler is idle once its last tone plus gap has fully elapsed
  function automatic bit idle_at(input int d, input int c);
    return (m_active[d] == 0) || (c >= m_start[d] + m_len[d] + gap_of(d));
  endfunction

  task automatic set_req(input int i, input logic [31:0] p, input logic [31:0] du,
                         input logic [31:0] l);
    req_period[i*W +: W] = p;
    req_duty[i*W +: W]   = du;
    req_len[i*W +: W]    = l;
  endtask

  task automatic model_edge();
    int n, w;
    n = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_active[d] = 0;
        m_ptr[d]    = 0;
      end else if (!idle_at(d, cyc)) begin
        if (stop) m_active[d] = 0;
      end else begin
        m_active[d] = 0;
        if (!stop && req != '0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr[d] + k) % N]) w = (m_ptr[d] + k) % N;
          m_active[d] = 1;
          m_start[d]  = n;
          m_owner[d]  = w;
          m_per[d]    = req_period[w*W +: W];
          m_duty[d]   = req_duty[w*W +: W];
          m_len[d]    = (req_len[w*W +: W] == 0) ? 1 : int'(req_len[w*W +: W]);
          m_ptr[d]    = (w + 1) % N;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int rel;
    logic [N-1:0] eg, ed;
    logic eb, ee;
    logic [31:0] ep, eu;
    for (int d = 0; d < 2; d++) begin
      eg = '0; ed = '0; eb = 1'b0; ee = 1'b0; ep = '0; eu = '0;
      rel = cyc - m_start[d];
      if (m_active[d] != 0) begin
        if (rel < m_len[d]) begin
          eg = (rel == 0) ? N'(1 << m_owner[d]) : '0;
          ee = (m_per[d] != 0);
          ep = m_per[d];
          eu = m_duty[d];
          eb = 1'b1;
        end else if (rel == m_len[d]) begin
          ed = N'(1 << m_owner[d]);
          eb = (gap_of(d) > 0);
        end else if (rel < m_len[d] + gap_of(d)) begin
          eb = 1'b1;
        end
      end
      chk("grant", d, 32'(d == 0 ? grant_a : grant_b), 32'(eg));
      chk("done",  d, 32'(d == 0 ? done_a  : done_b),  32'(ed));
      chk("busy",  d, 32'(d == 0 ? busy_a  : busy_b),  32'(eb));
      chk("en",    d, 32'(d == 0 ? en_a    : en_b),    32'(ee));
      chk("period", d, d == 0 ? per_a  : per_b,  ep);
      chk("duty",   d, d == 0 ? duty_a : duty_b, eu);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
    end
  endtask

  initial begin
    m_active = '{0, 0};
    m_start  = '{0, 0};
    m_len    = '{0, 0};
    m_owner  = '{0, 0};
    m_ptr    = '{0, 0};
    m_per    = '{0, 0};
    m_duty   = '{0, 0};
    rst = 1'b1; req = 4'b1111; stop = 1'b0;
    req_period = '0; req_duty = '0; req_len = '0;
    for (int i = 0; i < N; i++) set_req(i, 32'd1000 + i, 32'd77, 32'd3);
    applyStimulus(3);
    rst = 1'b0; req = '0;
    applyStimulus(2);

    $display("[TB] single tone on requester 2");
    set_req(2, 32'd8590, 32'd429496729, 32'd10);
    req = 4'b0100;
    applyStimulus(1);
    req = '0;
    applyStimulus(20);

    $display("[TB] round-robin with 1011 held");
    for (int i = 0; i < N; i++) set_req(i, 32'd2000 + i, 32'd500, 32'd3);
    req = 4'b1011;
    applyStimulus(45);
    req = '0;
    applyStimulus(12);

    $display("[TB] rest tone and zero length");
    set_req(1, 32'd0, 32'd123, 32'd5);
    req = 4'b0010;
    applyStimulus(1);
    req = '0;
    applyStimulus(12);
    set_req(0, 32'd3000, 32'd40, 32'd0);
    req = 4'b0001;
    applyStimulus(1);
    req = '0;
    applyStimulus(8);

    $display("[TB] abort mid-tone with pending request");
    set_req(0, 32'd500, 32'd9, 32'd10);
    set_req(3, 32'd700, 32'd11, 32'd2);
    req = 4'b0001;
    applyStimulus(1);
    req = 4'b1000;
    applyStimulus(3);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    applyStimulus(1);
    req = '0;
    applyStimulus(10);

    $display("[TB] stop versus request in idle");
    req = 4'b0001; stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    applyStimulus(1);
    req = '0;
    applyStimulus(10);

    $display("[TB] randomized traffic");
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom, $urandom,
                32'($urandom_range(0, 6)));
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      stop = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      applyStimulus(1);
    end
    rst = 1'b0; stop = 1'b0; req = '0;
    applyStimulus(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
